// File: rtl/adc_trigger_capture_if.sv
// ---------------------------------------------------------------------------
// adc_trigger_capture_if : sample, trigger-control and read-back signal bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface adc_trigger_capture_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 8
);
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic [DATA_W-1:0] trig_level;
  logic              trig_rising;
  logic              force_trig;
  logic              arm;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              waiting;
  logic              done;

  modport master (
    output sample_in, sample_valid, trig_level, trig_rising, force_trig, arm, rd_addr,
    input  rd_data, busy, waiting, done
  );

  modport slave (
    input  sample_in, sample_valid, trig_level, trig_rising, force_trig, arm, rd_addr,
    output rd_data, busy, waiting, done
  );
endinterface

`default_nettype wire

// File: rtl/adc_trigger_capture.sv
// ---------------------------------------------------------------------------
// adc_trigger_capture : ring-buffered, trigger-aligned ADC frame capture
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module adc_trigger_capture #(
  parameter int DATA_W  = 12,
  parameter int ADDR_W  = 8,
  parameter int PRETRIG = 64
) (
  input  wire                    clkADC,
  input  wire                    reset_n,
  adc_trigger_capture_if.slave   bus
);
  localparam int DEPTH    = 1 << ADDR_W;
  localparam int POST_LEN = DEPTH - PRETRIG;
  localparam int CNT_W    = ADDR_W + 1;

  localparam logic [CNT_W-1:0]  c_PRE_CNT  = CNT_W'(PRETRIG);
  localparam logic [CNT_W-1:0]  c_POST_CNT = CNT_W'(POST_LEN);
  localparam logic [ADDR_W-1:0] c_PRE_PTR  = ADDR_W'(PRETRIG);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] start_ptr_q, start_ptr_d;
  logic [CNT_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0]  post_cnt_q, post_cnt_d;
  logic              force_q, force_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              busy_q, busy_d;
  logic              waiting_q, waiting_d;
  logic              done_q, done_d;

  logic              wr_en;
  logic              trig_hit;
  logic [ADDR_W-1:0] rd_idx;

  logic [DATA_W-1:0] mem [DEPTH];

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    start_ptr_d = start_ptr_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    prev_d      = prev_q;
    force_d     = force_q | bus.force_trig;

    wr_en = bus.sample_valid && !bus.arm &&
            (state_q == S_PRE || state_q == S_WAIT || state_q == S_POST);

    if (bus.trig_rising)
      trig_hit = (prev_q < bus.trig_level) && (bus.sample_in >= bus.trig_level);
    else
      trig_hit = (prev_q > bus.trig_level) && (bus.sample_in <= bus.trig_level);
    // The sticky force flag only counts if it was already set before this sample
    trig_hit = trig_hit || force_q;

    if (bus.arm) begin
      state_d    = S_PRE;
      wr_ptr_d   = '0;
      pre_cnt_d  = '0;
      post_cnt_d = '0;
      force_d    = 1'b0;
    end else if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      prev_d   = bus.sample_in;
      unique case (state_q)
        S_PRE: begin
          pre_cnt_d = pre_cnt_q + 1'b1;
          if (pre_cnt_d == c_PRE_CNT) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (trig_hit) begin
            start_ptr_d = wr_ptr_q - c_PRE_PTR;
            post_cnt_d  = CNT_W'(1);
            force_d     = 1'b0;
            state_d     = (c_POST_CNT == CNT_W'(1)) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          post_cnt_d = post_cnt_q + 1'b1;
          if (post_cnt_d == c_POST_CNT) state_d = S_DONE;
        end
        default: state_d = state_q;
      endcase
    end

    busy_d    = (state_d == S_PRE) || (state_d == S_WAIT) || (state_d == S_POST);
    waiting_d = (state_d == S_WAIT);
    done_d    = (state_d == S_DONE);

    rd_idx    = start_ptr_q + bus.rd_addr;
    rd_data_d = mem[rd_idx];
  end

  always_ff @(posedge clkADC) begin
    if (wr_en) mem[wr_ptr_q] <= bus.sample_in;
  end

  always_ff @(posedge clkADC or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      start_ptr_q <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      force_q     <= 1'b0;
      prev_q      <= '0;
      rd_data_q   <= '0;
      busy_q      <= 1'b0;
      waiting_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      start_ptr_q <= start_ptr_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      force_q     <= force_d;
      prev_q      <= prev_d;
      rd_data_q   <= rd_data_d;
      busy_q      <= busy_d;
      waiting_q   <= waiting_d;
      done_q      <= done_d;
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.busy    = busy_q;
  assign bus.waiting = waiting_q;
  assign bus.done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_trigger_capture.sv
// ---------------------------------------------------------------------------
// tb_adc_trigger_capture : scoreboard bench for the trigger capture buffer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_adc_trigger_capture;
  localparam int DATA_W  = 12;
  localparam int ADDR_W  = 8;
  localparam int PRETRIG = 64;
  localparam int DEPTH   = 256;
  localparam int POSTN   = DEPTH - PRETRIG;

  logic clk;
  logic rst_n;

  adc_trigger_capture_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  adc_trigger_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PRETRIG(PRETRIG)) dut (
    .clkADC  (clk),
    .reset_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] stim [$];
  logic [DATA_W-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, expv);
    end
  endtask

  task automatic send(input logic [DATA_W-1:0] s);
    @(negedge clk);
    bus.sample_in    = s;
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  task automatic do_arm(input bit with_sample, input logic [DATA_W-1:0] s);
    @(negedge clk);
    bus.arm = 1'b1;
    if (with_sample) begin
      bus.sample_in    = s;
      bus.sample_valid = 1'b1;
    end
    @(negedge clk);
    bus.arm          = 1'b0;
    bus.sample_valid = 1'b0;
    chk("arm_busy", 32'(bus.busy), 32'd1);
    chk("arm_done", 32'(bus.done), 32'd0);
    chk("arm_wait", 32'(bus.waiting), 32'd0);
  endtask

  task automatic pulse_force();
    @(negedge clk);
    bus.force_trig = 1'b1;
    @(negedge clk);
    bus.force_trig = 1'b0;
  endtask

  function automatic int find_trig(input bit rising, input logic [DATA_W-1:0] lvl,
                                   input int force_idx);
    for (int i = PRETRIG; i < stim.size(); i++) begin
      logic [DATA_W-1:0] p;
      logic [DATA_W-1:0] c;
      p = stim[i-1];
      c = stim[i];
      if (force_idx >= 0 && i >= force_idx) return i;
      if (rising && p < lvl && c >= lvl) return i;
      if (!rising && p > lvl && c <= lvl) return i;
    end
    return -1;
  endfunction

  task automatic read_frame(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      logic [DATA_W-1:0] e;
      @(negedge clk);
      bus.rd_addr = ADDR_W'(a);
      @(negedge clk);
      e = exp_q.pop_front();
      if (bus.rd_data !== e) chk({tag, "_frame"}, 32'(bus.rd_data), 32'(e));
      else total++;
    end
  endtask

  task automatic read_one(input string tag, input int a, input logic [DATA_W-1:0] e);
    @(negedge clk);
    bus.rd_addr = ADDR_W'(a);
    @(negedge clk);
    chk(tag, 32'(bus.rd_data), 32'(e));
  endtask

  // stop_after >= 0 abandons the capture after that many samples (no read-back)
  task automatic run_capture(input string tag, input bit rising, input logic [DATA_W-1:0] lvl,
                             input int force_idx, input bit arm_with_sample, input int stop_after);
    int ti;
    int last;
    bus.trig_rising = rising;
    bus.trig_level  = lvl;
    ti = find_trig(rising, lvl, force_idx);
    if (ti < 0 || ti + POSTN - 1 >= stim.size()) begin
      chk({tag, "_stim_len"}, 32'd0, 32'd1);
      return;
    end
    last = ti + POSTN - 1;
    do_arm(arm_with_sample, 12'hABC);
    for (int i = 0; i <= last; i++) begin
      if (stop_after >= 0 && i == stop_after) return;
      if (i == force_idx) pulse_force();
      send(stim[i]);
      if (i == PRETRIG - 1) chk({tag, "_waiting"}, 32'(bus.waiting), 32'd1);
      if (i == ti && ti != last) chk({tag, "_post_busy"}, 32'(bus.busy), 32'd1);
      if (i == last - 1) chk({tag, "_done_early"}, 32'(bus.done), 32'd0);
    end
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    exp_q.delete();
    for (int k = 0; k < DEPTH; k++) exp_q.push_back(stim[ti - PRETRIG + k]);
    read_frame(tag);
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    bus.trig_level   = '0;
    bus.trig_rising  = 1'b1;
    bus.force_trig   = 1'b0;
    bus.arm          = 1'b0;
    bus.rd_addr      = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_wait", 32'(bus.waiting), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_rdata", 32'(bus.rd_data), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Ramp, rising through 0x800
    stim.delete();
    for (int k = 0; k < 320; k++) stim.push_back(12'((k * 16) % 4096));
    run_capture("ramp", 1'b1, 12'h800, -1, 1'b0, -1);
    read_one("ramp_rd64", 64, 12'h800);
    read_one("ramp_rd63", 63, 12'h7F0);
    read_one("ramp_rd0", 0, 12'h400);

    // Falling through 0x400
    stim.delete();
    for (int k = 0; k < 320; k++) stim.push_back((k * 16 > 'hA00) ? 12'h000 : 12'('hA00 - k * 16));
    run_capture("fall", 1'b0, 12'h400, -1, 1'b0, -1);
    read_one("fall_rdpre", PRETRIG, 12'h400);
    read_one("fall_rdpre_m1", PRETRIG - 1, 12'h410);

    // Forced trigger on constant input
    stim.delete();
    for (int k = 0; k < 300; k++) stim.push_back(12'h123);
    run_capture("force", 1'b1, 12'h800, 81, 1'b0, -1);

    // Long wait in WAIT_TRIG so the ring wraps before the trigger
    stim.delete();
    for (int k = 0; k < 600; k++) stim.push_back(12'(k));
    run_capture("wrap", 1'b1, 12'h180, -1, 1'b0, -1);

    // Abort mid-POST, re-arm with a coincident sample that must be dropped
    stim.delete();
    for (int k = 0; k < 320; k++) stim.push_back(12'((k * 16) % 4096));
    run_capture("abortA", 1'b1, 12'h800, -1, 1'b0, 150);
    chk("abort_busy_pre", 32'(bus.busy), 32'd1);
    stim.delete();
    for (int k = 0; k < 420; k++) stim.push_back(12'(32'h100 + k * 8));
    run_capture("rearm", 1'b1, 12'h800, -1, 1'b1, -1);

    // Asynchronous reset while waiting for a trigger
    stim.delete();
    for (int k = 0; k < 80; k++) stim.push_back(12'(k * 4));
    bus.trig_level  = 12'hF00;
    bus.trig_rising = 1'b1;
    do_arm(1'b0, 12'h000);
    for (int i = 0; i < 70; i++) send(stim[i]);
    chk("pre_rst_wait", 32'(bus.waiting), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_wait", 32'(bus.waiting), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_rdata", 32'(bus.rd_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) send(12'hFFF);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    chk("post_rst_done", 32'(bus.done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
